// File: rtl/sobel_pkg.sv
// sobel_pkg: shared defaults and state encoding for the Sobel frame sequencer
package sobel_pkg;
  localparam int IMG_W_DEF     = 320;
  localparam int IMG_H_DEF     = 240;
  localparam int PIX_W_DEF     = 8;
  localparam int ADDR_W_DEF    = 17;
  localparam int RD_LAT_DEF    = 1;
  localparam int FRAME_PIX_DEF = IMG_W_DEF * IMG_H_DEF;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;
endpackage

// File: rtl/rd_valid_pipe.sv
// rd_valid_pipe: aligns RAM read data with its issue strobe and registers it as the pixel stream
// Ports: i_clk, i_rst_n (async, active low), i_issue (read issued this cycle),
//        i_rd_data (RAM data), o_pix_val/o_pix_data (registered pixel), o_empty (no read in flight)
module rd_valid_pipe #(
  parameter int PIX_W  = 8,
  parameter int RD_LAT = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_issue,
  input  logic [PIX_W-1:0] i_rd_data,
  output logic             o_pix_val,
  output logic [PIX_W-1:0] o_pix_data,
  output logic             o_empty
);
  logic [RD_LAT-1:0] r_sh;
  logic              r_val;
  logic [PIX_W-1:0]  r_data;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_sh   <= '0;
      r_val  <= 1'b0;
      r_data <= '0;
    end else begin
      r_sh  <= (r_sh << 1) | RD_LAT'(i_issue);
      r_val <= r_sh[RD_LAT-1];
      // top bit of the strobe shift marks the cycle the RAM data is valid
      if (r_sh[RD_LAT-1]) r_data <= i_rd_data;
    end
  assign o_pix_val  = r_val;
  assign o_pix_data = r_data;
  assign o_empty    = ~|r_sh;
endmodule

// File: rtl/sobel_frame_sequencer.sv
// sobel_frame_sequencer: reads a frame row-major from image RAM and streams it to the Sobel datapath
// Ports: i_clk, i_rst_n (async, active low); i_start (begin frame), i_cont (auto-restart),
//        i_abort (stop issuing and drain), i_stall (hold issue); o_rd_en/o_rd_addr/i_rd_data (RAM);
//        o_pix_data/o_pix_val (pixel stream); o_busy, o_frame_done, o_frame_cnt (status)
module sobel_frame_sequencer
  import sobel_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int PIX_W  = PIX_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_cont,
  input  logic              i_abort,
  input  logic              i_stall,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [PIX_W-1:0]  i_rd_data,
  output logic [PIX_W-1:0]  o_pix_data,
  output logic              o_pix_val,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic [7:0]        o_frame_cnt
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IMG_W * IMG_H - 1);
  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_aborted;
  logic [7:0]        r_frame_cnt;
  logic              w_issue;
  logic              w_empty;
  // abort takes effect in the same cycle, so the read it coincides with is never issued
  assign w_issue = (r_state == S_FETCH) && !i_stall && !i_abort;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_aborted   <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE:
          if (i_start && !i_abort) begin
            r_state   <= S_FETCH;
            r_addr    <= '0;
            r_aborted <= 1'b0;
          end
        S_FETCH:
          if (i_abort) begin
            r_state   <= S_DRAIN;
            r_aborted <= 1'b1;
          end else if (!i_stall) begin
            if (r_addr == LAST) r_state <= S_DRAIN;
            else r_addr <= r_addr + 1'b1;
          end
        S_DRAIN:
          if (w_empty) r_state <= r_aborted ? S_IDLE : S_DONE;
        S_DONE: begin
          r_state     <= (i_cont && !i_abort) ? S_FETCH : S_IDLE;
          r_addr      <= '0;
          r_frame_cnt <= r_frame_cnt + 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  rd_valid_pipe #(.PIX_W(PIX_W), .RD_LAT(RD_LAT)) u_pipe (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_issue    (w_issue),
    .i_rd_data  (i_rd_data),
    .o_pix_val  (o_pix_val),
    .o_pix_data (o_pix_data),
    .o_empty    (w_empty)
  );
  assign o_rd_en      = w_issue;
  assign o_rd_addr    = r_addr;
  assign o_busy       = (r_state == S_FETCH) || (r_state == S_DRAIN);
  assign o_frame_done = (r_state == S_DONE);
  assign o_frame_cnt  = r_frame_cnt;
endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// tb_sobel_frame_sequencer: directed and randomized checks of the frame sequencer against a RAM/stream model
module tb_sobel_frame_sequencer;
  localparam int SN = 12;
  localparam int BN = 320 * 240;
  logic clk = 1'b0, rst_n = 1'b0, b_rst_n = 1'b0;
  logic start = 1'b0, cont = 1'b0, abort = 1'b0, stall = 1'b0, b_start = 1'b0;
  logic s_rd_en, s_pix_val, s_busy, s_frame_done;
  logic [16:0] s_rd_addr;
  logic [7:0] s_rd_data, s_pix_data, s_frame_cnt;
  logic b_rd_en, b_pix_val, b_busy, b_frame_done;
  logic [16:0] b_rd_addr;
  logic [7:0] b_rd_data, b_pix_data, b_frame_cnt;
  logic [7:0] ram_s [SN];
  logic [7:0] ram_b [BN];
  int checks = 0, errs = 0, cyc = 0;
  int iss_q[$], iss_cyc[$], done_cyc[$];
  logic [7:0] beat_q[$];
  int done_n = 0;
  logic h_en [2];
  int h_addr [2];
  logic [7:0] last_data;
  int b_next = 0, b_last = -1, b_beats = 0, b_addr_err = 0, b_data_err = 0, b_done_n = 0;
  int b_pend[$];

  always #5 clk = ~clk;

  sobel_frame_sequencer #(.IMG_W(4), .IMG_H(3), .ADDR_W(17), .PIX_W(8), .RD_LAT(1)) u_small (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_cont(cont), .i_abort(abort), .i_stall(stall),
    .o_rd_en(s_rd_en), .o_rd_addr(s_rd_addr), .i_rd_data(s_rd_data), .o_pix_data(s_pix_data),
    .o_pix_val(s_pix_val), .o_busy(s_busy), .o_frame_done(s_frame_done), .o_frame_cnt(s_frame_cnt));

  sobel_frame_sequencer u_big (
    .i_clk(clk), .i_rst_n(b_rst_n), .i_start(b_start), .i_cont(1'b0), .i_abort(1'b0), .i_stall(1'b0),
    .o_rd_en(b_rd_en), .o_rd_addr(b_rd_addr), .i_rd_data(b_rd_data), .o_pix_data(b_pix_data),
    .o_pix_val(b_pix_val), .o_busy(b_busy), .o_frame_done(b_frame_done), .o_frame_cnt(b_frame_cnt));

  always @(posedge clk) if (s_rd_en) s_rd_data <= ram_s[s_rd_addr];
  always @(posedge clk) if (b_rd_en) b_rd_data <= ram_b[b_rd_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // small DUT: every pixel must appear exactly two cycles after its read, carrying that RAM word
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      h_en = '{1'b0, 1'b0};
      h_addr = '{0, 0};
      last_data = 8'h00;
    end else begin
      chk("latency_val", 32'(s_pix_val), 32'(h_en[1]));
      if (h_en[1]) last_data = ram_s[h_addr[1]];
      chk("pix_data", 32'(s_pix_data), 32'(last_data));
      if (s_pix_val) beat_q.push_back(s_pix_data);
      if (s_rd_en) begin
        iss_q.push_back(int'(s_rd_addr));
        iss_cyc.push_back(cyc);
      end
      if (s_frame_done) begin
        done_n++;
        done_cyc.push_back(cyc);
      end
      h_en[1] = h_en[0];
      h_addr[1] = h_addr[0];
      h_en[0] = s_rd_en;
      h_addr[0] = int'(s_rd_addr);
    end
  end

  always @(negedge clk) if (b_rst_n) begin
    if (b_rd_en) begin
      if (int'(b_rd_addr) != b_next) b_addr_err++;
      b_next++;
      b_last = int'(b_rd_addr);
      b_pend.push_back(int'(b_rd_addr));
    end
    if (b_pix_val) begin
      b_beats++;
      if (b_pend.size() == 0 || b_pix_data !== ram_b[b_pend.pop_front()]) b_data_err++;
    end
    if (b_frame_done) b_done_n++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr;
    iss_q.delete();
    iss_cyc.delete();
    done_cyc.delete();
    beat_q.delete();
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int k = 0;
    while (done_n < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_done_reached"}, 32'(done_n >= target), 32'd1);
  endtask

  task automatic wait_addr(input int a, input string tag);
    int k = 0;
    while (int'(s_rd_addr) != a && k < 200) begin
      tick();
      k++;
    end
    chk({tag, "_addr_reached"}, 32'(s_rd_addr), 32'(a));
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while ((s_busy || s_frame_done) && k < 200) begin
      tick();
      k++;
    end
    chk({tag, "_idle"}, 32'(s_busy), 32'd0);
  endtask

  task automatic check_seq(input string tag, input int total, input int n_per);
    int bad_i = 0, bad_b = 0;
    chk({tag, "_issue_cnt"}, iss_q.size(), total);
    chk({tag, "_beat_cnt"}, beat_q.size(), total);
    foreach (iss_q[i]) if (iss_q[i] != i % n_per) bad_i++;
    foreach (beat_q[i]) if (beat_q[i] !== ram_s[i % n_per]) bad_b++;
    chk({tag, "_issue_order"}, bad_i, 0);
    chk({tag, "_beat_data"}, bad_b, 0);
  endtask

  initial begin
    int d0, b1, fc, k;
    foreach (ram_s[i]) ram_s[i] = 8'($urandom);
    foreach (ram_b[i]) ram_b[i] = 8'($urandom);
    repeat (2) tick();
    chk("rst_rd_en", 32'(s_rd_en), 0);
    chk("rst_rd_addr", 32'(s_rd_addr), 0);
    chk("rst_pix_val", 32'(s_pix_val), 0);
    chk("rst_pix_data", 32'(s_pix_data), 0);
    chk("rst_busy", 32'(s_busy), 0);
    chk("rst_frame_done", 32'(s_frame_done), 0);
    chk("rst_frame_cnt", 32'(s_frame_cnt), 0);
    rst_n = 1'b1;
    b_rst_n = 1'b1;
    tick();
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    fc = 0;
    // plain frame
    clr();
    pulse_start();
    wait_done(1, 100, "t1");
    repeat (3) tick();
    fc++;
    check_seq("t1", SN, SN);
    chk("t1_back_to_back", iss_cyc[SN-1] - iss_cyc[0], SN - 1);
    chk("t1_done_pulses", done_n, 1);
    chk("t1_frame_cnt", 32'(s_frame_cnt), fc);
    chk("t1_busy", 32'(s_busy), 0);
    // stall at address 6 for five cycles
    clr();
    d0 = done_n;
    pulse_start();
    wait_addr(6, "t2");
    stall = 1'b1;
    tick();
    b1 = beat_q.size();
    repeat (4) tick();
    chk("t2_issue_halted", iss_q.size(), 6);
    chk("t2_beats_after_stall", beat_q.size() - b1, 1);
    stall = 1'b0;
    wait_done(d0 + 1, 100, "t2");
    repeat (3) tick();
    fc++;
    check_seq("t2", SN, SN);
    chk("t2_frame_cnt", 32'(s_frame_cnt), fc);
    // random stall pattern across a whole frame
    clr();
    d0 = done_n;
    pulse_start();
    k = 0;
    while (done_n < d0 + 1 && k < 300) begin
      stall = 1'($urandom_range(0, 1));
      tick();
      k++;
    end
    stall = 1'b0;
    chk("t2r_done", done_n, d0 + 1);
    repeat (3) tick();
    fc++;
    check_seq("t2r", SN, SN);
    // abort at address 5
    clr();
    d0 = done_n;
    pulse_start();
    wait_addr(5, "t3");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_idle("t3");
    repeat (3) tick();
    check_seq("t3", 5, SN);
    chk("t3_no_done", done_n, d0);
    chk("t3_frame_cnt", 32'(s_frame_cnt), fc);
    // abort wins over start in IDLE
    clr();
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    tick();
    chk("abort_beats_start_busy", 32'(s_busy), 0);
    chk("abort_beats_start_issue", iss_q.size(), 0);
    // continuous mode for three frames, with a start while busy
    clr();
    d0 = done_n;
    cont = 1'b1;
    pulse_start();
    repeat (5) tick();
    pulse_start();
    wait_done(d0 + 2, 100, "t4a");
    tick();
    cont = 1'b0;
    wait_done(d0 + 3, 100, "t4b");
    repeat (5) tick();
    fc += 3;
    check_seq("t4", 3 * SN, SN);
    chk("t4_done_pulses", done_n - d0, 3);
    chk("t4_frame_cnt", 32'(s_frame_cnt), fc);
    chk("t4_gap1", iss_cyc[SN], done_cyc[0] + 1);
    chk("t4_gap2", iss_cyc[2*SN], done_cyc[1] + 1);
    chk("t4_stopped", 32'(s_busy), 0);
    // asynchronous reset mid-fetch at address 7
    clr();
    pulse_start();
    wait_addr(7, "t5");
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rd_en", 32'(s_rd_en), 0);
    chk("t5_rd_addr", 32'(s_rd_addr), 0);
    chk("t5_pix_val", 32'(s_pix_val), 0);
    chk("t5_pix_data", 32'(s_pix_data), 0);
    chk("t5_busy", 32'(s_busy), 0);
    chk("t5_frame_done", 32'(s_frame_done), 0);
    chk("t5_frame_cnt", 32'(s_frame_cnt), 0);
    fc = 0;
    tick();
    rst_n = 1'b1;
    tick();
    clr();
    d0 = done_n;
    pulse_start();
    wait_done(d0 + 1, 100, "t5");
    repeat (3) tick();
    fc++;
    check_seq("t5", SN, SN);
    chk("t5_frame_cnt_after", 32'(s_frame_cnt), fc);
    // frame count wrap
    clr();
    d0 = done_n;
    cont = 1'b1;
    pulse_start();
    wait_done(d0 + 254, 6000, "t6a");
    tick();
    chk("t6_cnt_255", 32'(s_frame_cnt), (fc + 254) % 256);
    cont = 1'b0;
    wait_done(d0 + 255, 60, "t6b");
    repeat (3) tick();
    chk("t6_wrap", 32'(s_frame_cnt), (fc + 255) % 256);
    check_seq("t6", 255 * SN, SN);
    // full-size frame running alongside
    k = 0;
    while (b_done_n < 1 && k < 90000) begin
      @(negedge clk);
      k++;
    end
    repeat (3) tick();
    chk("full_done", b_done_n, 1);
    chk("full_last_addr", b_last, BN - 1);
    chk("full_beats", b_beats, BN);
    chk("full_addr_order", b_addr_err, 0);
    chk("full_data", b_data_err, 0);
    chk("full_frame_cnt", 32'(b_frame_cnt), 1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
